// File: rtl/aes_serial_if.sv
// Host-link and core-handshake bundle for the AES serial responder.
// master = host/core side, slave = responder side.
interface aes_serial_if #(
    parameter int DATA_BITS = 128,
    parameter int KEY_BITS  = 128
);
    logic                 cs_n;
    logic                 mosi;
    logic                 miso;
    logic [DATA_BITS-1:0] core_data;
    logic [KEY_BITS-1:0]  core_key;
    logic                 core_start;
    logic                 core_done;
    logic [DATA_BITS-1:0] core_result;
    logic                 busy;
    logic                 frame_err;

    modport master (
        output cs_n, mosi, core_done, core_result,
        input  miso, core_data, core_key, core_start, busy, frame_err
    );

    modport slave (
        input  cs_n, mosi, core_done, core_result,
        output miso, core_data, core_key, core_start, busy, frame_err
    );
endinterface

// File: rtl/aes_serial_responder.sv
// Target end of the 1-bit host link: deserializes block+key LSB first, hands them to the
// cipher core with a start/done handshake, then streams the 128-bit result back on miso.
module aes_serial_responder #(
    parameter int DATA_BITS = 128,
    parameter int KEY_BITS  = 128
) (
    input  logic       clk,
    input  logic       rst,
    aes_serial_if.slave bus
);
    localparam int TOTAL = DATA_BITS + KEY_BITS;
    localparam int CW    = $clog2(TOTAL);
    localparam int DW    = $clog2(DATA_BITS);
    localparam int KW    = $clog2(KEY_BITS);
    localparam int TW    = DW + 1;

    typedef enum logic [2:0] {S_RX, S_START, S_WAIT, S_TX, S_HOLD} state_t;

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [TW-1:0]        tx_cnt;
    logic [DATA_BITS-1:0] result;
    logic [KW-1:0]        key_idx;
    logic                 abort;

    assign key_idx = KW'(bit_cnt - CW'(DATA_BITS));
    // Host dropping CS between handing off the block and the end of TX kills the transaction.
    assign abort   = bus.cs_n && (state == S_START || state == S_WAIT || state == S_TX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_RX;
            bit_cnt        <= '0;
            tx_cnt         <= '0;
            result         <= '0;
            bus.miso       <= 1'b0;
            bus.core_start <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.core_data  <= '0;
            bus.core_key   <= '0;
        end else begin
            bus.core_start <= 1'b0;
            if (abort) begin
                bus.frame_err <= 1'b1;
                bus.miso      <= 1'b0;
                bus.busy      <= 1'b0;
                bit_cnt       <= '0;
                state         <= S_RX;
            end else begin
                case (state)
                    S_RX: begin
                        if (bus.cs_n) begin
                            if (bit_cnt != '0) bus.frame_err <= 1'b1;
                            bit_cnt  <= '0;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.busy <= 1'b1;
                            if (bit_cnt == '0) bus.frame_err <= 1'b0;
                            if (bit_cnt < CW'(DATA_BITS))
                                bus.core_data[bit_cnt[DW-1:0]] <= bus.mosi;
                            else
                                bus.core_key[key_idx] <= bus.mosi;
                            // bit_cnt parks on the last index until the frame is closed
                            if (bit_cnt == CW'(TOTAL - 1)) begin
                                state          <= S_START;
                                bus.core_start <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    S_START: state <= S_WAIT;
                    S_WAIT: begin
                        if (bus.core_done) begin
                            result   <= bus.core_result;
                            bus.miso <= bus.core_result[0];
                            tx_cnt   <= TW'(1);
                            state    <= S_TX;
                        end
                    end
                    S_TX: begin
                        if (tx_cnt == TW'(DATA_BITS)) begin
                            bus.miso <= 1'b0;
                            bus.busy <= 1'b0;
                            state    <= S_HOLD;
                        end else begin
                            bus.miso <= result[tx_cnt[DW-1:0]];
                            tx_cnt   <= tx_cnt + TW'(1);
                        end
                    end
                    S_HOLD: begin
                        if (bus.cs_n) begin
                            bit_cnt <= '0;
                            state   <= S_RX;
                        end
                    end
                    default: state <= S_RX;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_serial_responder.sv
// Bench for aes_serial_responder: three instances (128/192/256-bit keys) behind one driver,
// a queue-based transaction model checked every cycle, plus FIPS-197 literal expectations.
module tb_aes_serial_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_v, cs_v, mosi_v, done_v;
    logic [127:0] res_v;
    int           sel;

    aes_serial_if #(.KEY_BITS(128)) b0 ();
    aes_serial_if #(.KEY_BITS(192)) b1 ();
    aes_serial_if #(.KEY_BITS(256)) b2 ();

    assign b0.cs_n = (sel == 0) ? cs_v : 1'b1;
    assign b1.cs_n = (sel == 1) ? cs_v : 1'b1;
    assign b2.cs_n = (sel == 2) ? cs_v : 1'b1;
    assign b0.core_done = (sel == 0) ? done_v : 1'b0;
    assign b1.core_done = (sel == 1) ? done_v : 1'b0;
    assign b2.core_done = (sel == 2) ? done_v : 1'b0;
    assign b0.mosi = mosi_v;
    assign b1.mosi = mosi_v;
    assign b2.mosi = mosi_v;
    assign b0.core_result = res_v;
    assign b1.core_result = res_v;
    assign b2.core_result = res_v;

    aes_serial_responder #(.KEY_BITS(128)) u0 (.clk(clk), .rst(rst_v), .bus(b0));
    aes_serial_responder #(.KEY_BITS(192)) u1 (.clk(clk), .rst(rst_v), .bus(b1));
    aes_serial_responder #(.KEY_BITS(256)) u2 (.clk(clk), .rst(rst_v), .bus(b2));

    logic         miso_m, busy_m, start_m, ferr_m;
    logic [127:0] data_m;
    logic [255:0] key_m;

    always_comb begin
        miso_m  = b0.miso;
        busy_m  = b0.busy;
        start_m = b0.core_start;
        ferr_m  = b0.frame_err;
        data_m  = b0.core_data;
        key_m   = {128'b0, b0.core_key};
        if (sel == 1) begin
            miso_m  = b1.miso;
            busy_m  = b1.busy;
            start_m = b1.core_start;
            ferr_m  = b1.frame_err;
            data_m  = b1.core_data;
            key_m   = {64'b0, b1.core_key};
        end else if (sel == 2) begin
            miso_m  = b2.miso;
            busy_m  = b2.busy;
            start_m = b2.core_start;
            ferr_m  = b2.frame_err;
            data_m  = b2.core_data;
            key_m   = b2.core_key;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic cmp_b(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
        end
    endtask

    task automatic cmp_i(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic cmp_w(input string n, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Transaction model: phase 0 collect, 1 handoff, 2 await core, 3 stream, 4 wait for CS release
    int           mph;
    bit           rxq[$];
    bit           txq[$];
    logic         exp_miso, exp_busy, exp_start, exp_ferr;
    logic [127:0] exp_data;
    logic [255:0] exp_key;
    bit           chk_vec, chk_en;
    int           start_cnt;

    function automatic int mk();
        return (sel == 0) ? 128 : (sel == 1) ? 192 : 256;
    endfunction

    task automatic model_edge(input bit r, input bit cs, input bit mo, input bit dn);
        exp_start = 1'b0;
        chk_vec   = 1'b0;
        if (r) begin
            mph = 0; rxq.delete(); txq.delete();
            exp_miso = 0; exp_busy = 0; exp_ferr = 0;
            exp_data = '0; exp_key = '0; chk_vec = 1'b1;
            return;
        end
        if (cs && (mph == 1 || mph == 2 || mph == 3)) begin
            exp_ferr = 1; exp_miso = 0; exp_busy = 0; mph = 0; rxq.delete();
            return;
        end
        case (mph)
            0: if (cs) begin
                   if (rxq.size() != 0) exp_ferr = 1;
                   rxq.delete();
                   exp_busy = 0;
               end else begin
                   if (rxq.size() == 0) exp_ferr = 0;
                   rxq.push_back(mo);
                   exp_busy = 1;
                   if (rxq.size() == 128 + mk()) begin
                       exp_data = '0; exp_key = '0;
                       for (int i = 0; i < 128; i++) exp_data[i] = rxq[i];
                       for (int i = 0; i < mk(); i++) exp_key[i] = rxq[128 + i];
                       rxq.delete();
                       exp_start = 1; mph = 1;
                   end
               end
            1: mph = 2;
            2: if (dn) begin
                   txq.delete();
                   for (int i = 0; i < 128; i++) txq.push_back(res_v[i]);
                   exp_miso = txq.pop_front();
                   mph = 3;
               end
            3: if (txq.size() == 0) begin
                   exp_miso = 0; exp_busy = 0; mph = 4;
               end else begin
                   exp_miso = txq.pop_front();
               end
            default: if (cs) begin mph = 0; rxq.delete(); end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_b("miso", miso_m, exp_miso);
            cmp_b("busy", busy_m, exp_busy);
            cmp_b("core_start", start_m, exp_start);
            cmp_b("frame_err", ferr_m, exp_ferr);
            if (exp_start || chk_vec) begin
                cmp_w("core_data", {128'b0, data_m}, {128'b0, exp_data});
                cmp_w("core_key", key_m, exp_key);
            end
        end
    end

    function automatic bit rb();
        return 1'($urandom());
    endfunction

    task automatic tick(input bit cs, input bit mo, input bit dn);
        cs_v = cs; mosi_v = mo; done_v = dn;
        @(posedge clk);
        #2;
        model_edge(rst_v, cs, mo, dn);
        if (start_m) start_cnt++;
    endtask

    task automatic reset_checks(input string n);
        cmp_b({n, "_miso"}, miso_m, 1'b0);
        cmp_b({n, "_busy"}, busy_m, 1'b0);
        cmp_b({n, "_start"}, start_m, 1'b0);
        cmp_b({n, "_ferr"}, ferr_m, 1'b0);
        cmp_w({n, "_data"}, {128'b0, data_m}, 256'b0);
        cmp_w({n, "_key"}, key_m, 256'b0);
    endtask

    task automatic select(input int s);
        chk_en = 1'b0;
        sel = s;
        rst_v = 1'b1;
        tick(1, 0, 0);
        rst_v = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_frame(input int K, input logic [127:0] d, input logic [255:0] k,
                             input logic [127:0] res, input int lat, input bit hold,
                             input int abort_rx, input int abort_tx, input int rst_at,
                             input int rst_wait);
        logic [127:0] w, cd;
        logic [255:0] ck;
        int           sc;
        bit           b;
        start_cnt = 0; sc = 0; res_v = res; w = '0; cd = '0; ck = '0;
        for (int i = 0; i < 128 + K; i++) begin
            b = (i < 128) ? d[i] : k[i - 128];
            if (i == abort_rx) begin
                tick(1, b, 0);
                cmp_b("abort_rx_ferr", ferr_m, 1'b1);
                cmp_b("abort_rx_busy", busy_m, 1'b0);
                cmp_i("abort_rx_nostart", start_cnt, 0);
                return;
            end
            if (i == rst_at) begin
                rst_v = 1'b1; tick(0, b, 0); rst_v = 1'b0;
                reset_checks("rst_rx");
                tick(1, 0, 0);
                return;
            end
            tick(0, b, 0);
            if (i == 0) cmp_b("ferr_clr_bit0", ferr_m, 1'b0);
            if (start_m) begin sc = i + 2; cd = data_m; ck = key_m; end
        end
        cmp_i("start_cycle", sc, 129 + K);
        cmp_w("core_data_at_start", {128'b0, cd}, {128'b0, d});
        cmp_w("core_key_at_start", ck, k);
        for (int j = 0; j < lat; j++) begin
            if (j == rst_wait) begin
                rst_v = 1'b1; tick(0, rb(), 0); rst_v = 1'b0;
                reset_checks("rst_wait");
                for (int q = 0; q < 3; q++) begin
                    tick(1, 0, 1);
                    cmp_b("no_miso_after_rst", miso_m, 1'b0);
                end
                return;
            end
            tick(0, rb(), 0);
        end
        tick(0, rb(), 1);
        w[0] = miso_m;
        for (int j = 1; j < 128; j++) begin
            if (j == abort_tx) begin
                tick(1, 0, hold);
                cmp_b("abort_tx_miso", miso_m, 1'b0);
                cmp_b("abort_tx_busy", busy_m, 1'b0);
                cmp_b("abort_tx_ferr", ferr_m, 1'b1);
                return;
            end
            tick(0, rb(), hold);
            w[j] = miso_m;
        end
        tick(0, rb(), hold);
        cmp_b("tail_miso", miso_m, 1'b0);
        cmp_b("tail_busy", busy_m, 1'b0);
        cmp_w("result_word", {128'b0, w}, {128'b0, res});
        cmp_i("start_once", start_cnt, 1);
        tick(1, 0, 0);
    endtask

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] R256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        int           kk, lat, ab;
        logic [127:0] d, r;
        logic [255:0] k;
        chk_en = 1'b0; sel = 0; rst_v = 1'b1;
        cs_v = 1'b1; mosi_v = 1'b0; done_v = 1'b0; res_v = '0;
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk_en = 1'b1;
        reset_checks("reset");
        rst_v = 1'b0;
        tick(1, 0, 0);

        run_frame(128, PT, K128, R128, 10, 0, -1, -1, -1, -1);
        select(1);
        run_frame(192, PT, K192, R192, 10, 0, -1, -1, -1, -1);
        select(2);
        run_frame(256, PT, K256, R256, 10, 0, -1, -1, -1, -1);
        select(0);

        run_frame(128, PT, K128, R128, 10, 0, 100, -1, -1, -1);
        run_frame(128, PT, K128, R128, 10, 0, -1, -1, -1, -1);
        run_frame(128, PT, K128, R128, 10, 0, -1, 40, -1, -1);
        run_frame(128, PT, K128, R128, 5, 0, -1, -1, -1, -1);
        run_frame(128, PT, K128, R128, 10, 0, -1, -1, 200, -1);
        run_frame(128, PT, K128, R128, 10, 0, -1, -1, -1, 5);
        run_frame(128, PT, K128, R128, 3, 0, -1, -1, -1, -1);
        run_frame(128, PT, K128, ~R128, 1, 1, -1, -1, -1, -1);

        for (int n = 0; n < 12; n++) begin
            select(int'($urandom_range(0, 2)));
            kk  = mk();
            d   = {$urandom(), $urandom(), $urandom(), $urandom()};
            r   = {$urandom(), $urandom(), $urandom(), $urandom()};
            k   = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            k   = k & ((256'd1 << kk) - 256'd1);
            lat = int'($urandom_range(1, 15));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 127 + kk)) : -1;
            run_frame(kk, d, k, r, lat, 1'($urandom()), ab, -1, -1, -1);
            if (ab >= 0) run_frame(kk, d, k, r, lat, 0, -1, -1, -1, -1);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
